// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic operand feeder: FSM states,
// buffer-select encodings and the feed-length calculation.
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } feeder_state_t;

  localparam logic SEL_X = 1'b0;
  localparam logic SEL_W = 1'b1;

  // Cycles needed for the last skewed operand pair to reach the far corner PE.
  function automatic int feed_cycles(input int m, input int n, input int k);
    return m + n + k - 2;
  endfunction

endpackage

// File: rtl/skew_operand_buf.sv
// Operand register file with a per-lane skewed lookup: lane l at feed cycle t
// presents element (l, t-l) of the stored matrix, or zero outside the band.
module skew_operand_buf
  import systolic_pkg::*;
#(
  parameter int LANES      = 5,
  parameter int DEPTH_N    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 4,
  parameter int TW         = 4,
  parameter bit TRANSPOSE  = 1'b0
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic [TW-1:0]               rd_t,
  output logic [LANES*DATA_WIDTH-1:0] lanes
);

  localparam int DEPTH = LANES * DEPTH_N;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // X is stored row-major per lane (l*N+k); W is stored k-major (k*K+l).
  function automatic int elem_index(input int l, input int k);
    return TRANSPOSE ? (k * LANES + l) : (l * DEPTH_N + k);
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem[IW'(wr_addr)] <= wr_data;
    end
  end

  always_comb begin
    int k;
    k     = 0;
    lanes = '0;
    for (int l = 0; l < LANES; l++) begin
      k = int'(rd_t) - l;
      if ((k >= 0) && (k < DEPTH_N)) begin
        lanes[l*DATA_WIDTH +: DATA_WIDTH] = mem[IW'(elem_index(l, k))];
      end
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Buffers X and W, then clears and streams them diagonally skewed into an
// output-stationary systolic array, pulsing done once the products are final.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int M          = 5,
  parameter int N          = 3,
  parameter int K          = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DRAIN      = 2,
  localparam int AW        = $clog2(((M * N) > (N * K)) ? (M * N) : (N * K))
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [AW-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    start,
  output logic                    arr_clr,
  output logic [DATA_WIDTH*M-1:0] x_out,
  output logic [DATA_WIDTH*K-1:0] w_out,
  output logic                    feed_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int F    = feed_cycles(M, N, K);
  localparam int CMAX = (F > DRAIN) ? F : DRAIN;
  localparam int TW   = $clog2(CMAX + 1);

  feeder_state_t         state;
  logic [TW-1:0]         cnt;
  logic [TW-1:0]         rd_t;
  logic                  x_we;
  logic                  w_we;
  logic [DATA_WIDTH*M-1:0] x_lanes;
  logic [DATA_WIDTH*K-1:0] w_lanes;

  assign x_we = wr_en && (state == ST_IDLE) && (wr_sel == SEL_X);
  assign w_we = wr_en && (state == ST_IDLE) && (wr_sel == SEL_W);

  // Outputs are registered, so the lookup runs one feed cycle ahead of cnt.
  assign rd_t = (state == ST_FEED) ? (cnt + TW'(1)) : '0;

  skew_operand_buf #(
    .LANES(M), .DEPTH_N(N), .DATA_WIDTH(DATA_WIDTH), .AW(AW), .TW(TW), .TRANSPOSE(1'b0)
  ) u_x_buf (
    .clk(clk), .wr_en(x_we), .wr_addr(wr_addr), .wr_data(wr_data), .rd_t(rd_t), .lanes(x_lanes)
  );

  skew_operand_buf #(
    .LANES(K), .DEPTH_N(N), .DATA_WIDTH(DATA_WIDTH), .AW(AW), .TW(TW), .TRANSPOSE(1'b1)
  ) u_w_buf (
    .clk(clk), .wr_en(w_we), .wr_addr(wr_addr), .wr_data(wr_data), .rd_t(rd_t), .lanes(w_lanes)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      arr_clr    <= 1'b0;
      x_out      <= '0;
      w_out      <= '0;
      feed_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_CLR;
            arr_clr <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_CLR: begin
          state      <= ST_FEED;
          arr_clr    <= 1'b0;
          cnt        <= '0;
          feed_valid <= 1'b1;
          x_out      <= x_lanes;
          w_out      <= w_lanes;
        end
        ST_FEED: begin
          if (cnt == TW'(F - 1)) begin
            cnt        <= '0;
            feed_valid <= 1'b0;
            x_out      <= '0;
            w_out      <= '0;
            if (DRAIN == 0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_DRAIN;
            end
          end else begin
            cnt   <= cnt + TW'(1);
            x_out <= x_lanes;
            w_out <= w_lanes;
          end
        end
        ST_DRAIN: begin
          if (cnt == TW'(DRAIN - 1)) begin
            cnt   <= '0;
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench: matrix/skew reference model, behavioural PE array for
// end-to-end products, table-driven skew points and randomized runs.
module tb_systolic_skew_feeder;

  localparam int M     = 5;
  localparam int N     = 3;
  localparam int K     = 4;
  localparam int DW    = 32;
  localparam int DRAIN = 2;
  localparam int F     = M + N + K - 2;
  localparam int AW    = 4;
  localparam int XW    = M * DW;
  localparam int WW    = K * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          wr_sel;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          arr_clr;
  logic [XW-1:0] x_out;
  logic [WW-1:0] w_out;
  logic          feed_valid;
  logic          busy;
  logic          done;

  systolic_skew_feeder #(
    .M(M), .N(N), .K(K), .DATA_WIDTH(DW), .DRAIN(DRAIN)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .arr_clr(arr_clr), .x_out(x_out),
    .w_out(w_out), .feed_valid(feed_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference matrices as the host believes them to be stored.
  logic [DW-1:0] xm [M][N];
  logic [DW-1:0] wm [N][K];

  logic [XW-1:0] xTrace [F];
  logic [WW-1:0] wTrace [F];
  logic [XW-1:0] prevX  [F];
  logic [WW-1:0] prevW  [F];

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural output-stationary array driven by the feeder outputs.
  logic [DW-1:0] acc [M][K];
  logic [DW-1:0] xr  [M][K];
  logic [DW-1:0] wr  [M][K];

  function automatic logic [DW-1:0] peX(input int i, input int j);
    return (j == 0) ? x_out[i*DW +: DW] : xr[i][j-1];
  endfunction

  function automatic logic [DW-1:0] peW(input int i, input int j);
    return (i == 0) ? w_out[j*DW +: DW] : wr[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < K; j++) begin
        if (rst || arr_clr) begin
          acc[i][j] <= '0;
          xr[i][j]  <= '0;
          wr[i][j]  <= '0;
        end else begin
          xr[i][j]  <= peX(i, j);
          wr[i][j]  <= peW(i, j);
          acc[i][j] <= acc[i][j] + peX(i, j) * peW(i, j);
        end
      end
    end
  end

  function automatic logic [XW-1:0] expX(input int t);
    logic [XW-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++) begin
      if ((t - i >= 0) && (t - i < N)) r[i*DW +: DW] = xm[i][t-i];
    end
    return r;
  endfunction

  function automatic logic [WW-1:0] expW(input int t);
    logic [WW-1:0] r;
    r = '0;
    for (int j = 0; j < K; j++) begin
      if ((t - j >= 0) && (t - j < N)) r[j*DW +: DW] = wm[t-j][j];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Host write; the model follows only writes the feeder must accept.
  task automatic applyStimulus(input logic sel, input int addr, input logic [DW-1:0] data);
    if (sel == 1'b0 && addr < M * N) xm[addr / N][addr % N] = data;
    if (sel == 1'b1 && addr < N * K) wm[addr / K][addr % K] = data;
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = AW'(addr);
    wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic checkProduct(input string name);
    logic [DW-1:0] y;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < K; j++) begin
        y = '0;
        for (int k = 0; k < N; k++) y = y + xm[i][k] * wm[k][j];
        checkOutput(name, XW'(acc[i][j]), XW'(y));
      end
    end
  endtask

  // Full run from the start pulse; optionally pokes start or a write mid-feed.
  task automatic runAndCheck(input string name, input int injStartT, input int injWrT);
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    checkOutput({name, ".clr_ctrl"}, XW'({arr_clr, feed_valid, busy, done}), XW'(4'b1010));
    checkOutput({name, ".clr_x"}, x_out, '0);
    for (int t = 0; t < F; t++) begin
      if (t == injStartT) start = 1'b1;
      if (t == injWrT) begin
        wr_en   = 1'b1;
        wr_sel  = 1'($urandom_range(1));
        wr_addr = AW'($urandom_range(N * K - 1));
        wr_data = $urandom;
      end
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      xTrace[t] = x_out;
      wTrace[t] = w_out;
      checkOutput({name, ".feed_x"}, x_out, expX(t));
      checkOutput({name, ".feed_w"}, XW'(w_out), XW'(expW(t)));
      checkOutput({name, ".feed_ctrl"}, XW'({arr_clr, feed_valid, busy, done}), XW'(4'b0110));
    end
    for (int d = 0; d < DRAIN; d++) begin
      tick();
      checkOutput({name, ".drain_ctrl"}, XW'({arr_clr, feed_valid, busy, done}), XW'(4'b0010));
      checkOutput({name, ".drain_ops"}, x_out | XW'(w_out), '0);
    end
    tick();
    checkOutput({name, ".done_ctrl"}, XW'({arr_clr, feed_valid, busy, done}), XW'(4'b0011));
    checkProduct({name, ".y"});
    tick();
    checkOutput({name, ".idle_ctrl"}, XW'({arr_clr, feed_valid, busy, done}), XW'(4'b0000));
  endtask

  typedef struct {
    int            t;
    bit            isW;
    int            lane;
    logic [DW-1:0] exp;
  } skew_vec_t;

  skew_vec_t skewTab [23];

  initial begin
    skewTab[0]  = '{0, 1'b0, 0, 32'd0};
    skewTab[1]  = '{0, 1'b1, 0, 32'd0};
    skewTab[2]  = '{1, 1'b0, 0, 32'd1};
    skewTab[3]  = '{1, 1'b0, 1, 32'd10};
    skewTab[4]  = '{1, 1'b1, 0, 32'd100};
    skewTab[5]  = '{1, 1'b1, 1, 32'd1};
    skewTab[6]  = '{2, 1'b0, 0, 32'd2};
    skewTab[7]  = '{2, 1'b0, 1, 32'd11};
    skewTab[8]  = '{2, 1'b0, 2, 32'd20};
    skewTab[9]  = '{2, 1'b1, 0, 32'd200};
    skewTab[10] = '{2, 1'b1, 1, 32'd101};
    skewTab[11] = '{2, 1'b1, 2, 32'd2};
    skewTab[12] = '{4, 1'b0, 0, 32'd0};
    skewTab[13] = '{4, 1'b0, 2, 32'd22};
    skewTab[14] = '{4, 1'b0, 3, 32'd31};
    skewTab[15] = '{4, 1'b0, 4, 32'd40};
    skewTab[16] = '{4, 1'b1, 1, 32'd0};
    skewTab[17] = '{4, 1'b1, 2, 32'd202};
    skewTab[18] = '{4, 1'b1, 3, 32'd103};
    skewTab[19] = '{6, 1'b0, 3, 32'd0};
    skewTab[20] = '{6, 1'b0, 4, 32'd42};
    skewTab[21] = '{9, 1'b0, 4, 32'd0};
    skewTab[22] = '{9, 1'b1, 3, 32'd0};

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_sel  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    tick();
    tick();
    checkOutput("reset_x", x_out, '0);
    checkOutput("reset_w", XW'(w_out), '0);
    checkOutput("reset_ctrl", XW'({arr_clr, feed_valid, busy, done}), XW'(4'b0000));
    rst = 1'b0;
    tick();

    // Skew pattern X[i][k]=10i+k, W[k][j]=100k+j.
    for (int i = 0; i < M; i++)
      for (int k = 0; k < N; k++) applyStimulus(1'b0, i * N + k, DW'(10 * i + k));
    for (int k = 0; k < N; k++)
      for (int j = 0; j < K; j++) applyStimulus(1'b1, k * K + j, DW'(100 * k + j));
    runAndCheck("skew", -1, -1);
    for (int v = 0; v < 23; v++) begin
      if (skewTab[v].isW)
        checkOutput($sformatf("skew_tab%0d", v), XW'(wTrace[skewTab[v].t][skewTab[v].lane*DW +: DW]), XW'(skewTab[v].exp));
      else
        checkOutput($sformatf("skew_tab%0d", v), XW'(xTrace[skewTab[v].t][skewTab[v].lane*DW +: DW]), XW'(skewTab[v].exp));
    end

    // Back-to-back replay without rewrites; arr_clr must wipe the old sums.
    prevX = xTrace;
    prevW = wTrace;
    runAndCheck("replay", -1, -1);
    for (int t = 0; t < F; t++) begin
      checkOutput("replay_trace_x", xTrace[t], prevX[t]);
      checkOutput("replay_trace_w", XW'(wTrace[t]), XW'(prevW[t]));
    end

    // Out-of-range writes, then a run with start and writes poked mid-feed.
    applyStimulus(1'b0, 15, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 12, 32'hBAD0_0001);
    applyStimulus(1'b1, 15, 32'hBAD0_0002);
    runAndCheck("illegal", 3, 5);
    runAndCheck("after_illegal", -1, -1);

    // Reset at t=4, then a clean full run.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t <= 4; t++) tick();
    checkOutput("midfeed_t4_x", x_out, expX(4));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midreset_ops", x_out | XW'(w_out), '0);
    checkOutput("midreset_ctrl", XW'({arr_clr, feed_valid, busy, done}), XW'(4'b0000));
    tick();
    checkOutput("midreset_idle", XW'({arr_clr, feed_valid, busy, done}), XW'(4'b0000));
    runAndCheck("post_reset", -1, -1);

    // Write X[0][0]=7 in the same cycle as start.
    xm[0][0] = 32'd7;
    wr_en    = 1'b1;
    wr_sel   = 1'b0;
    wr_addr  = '0;
    wr_data  = 32'd7;
    runAndCheck("same_cycle", -1, -1);
    checkOutput("same_cycle_row0_t0", XW'(xTrace[0][DW-1:0]), XW'(32'd7));

    // Randomized matrices and illegal traffic.
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < M * N; a++) applyStimulus(1'b0, a, $urandom);
      for (int a = 0; a < N * K; a++) applyStimulus(1'b1, a, $urandom);
      applyStimulus(1'b0, 15, $urandom);
      applyStimulus(1'b1, $urandom_range(15, N * K), $urandom);
      runAndCheck($sformatf("rand%0d", r), $urandom_range(F - 1), $urandom_range(F - 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
